// File: rtl/pi1_intctrl_pkg.sv
// Shared constants for the pi1 interrupt controller: bus opcodes, register
// offsets and the "no interrupt" read value.
package pi1_intctrl_pkg;

    localparam logic [1:0] PINOOP = 2'd0;
    localparam logic [1:0] PIWROP = 2'd1;
    localparam logic [1:0] PIRDOP = 2'd2;
    localparam logic [1:0] PIRWOP = 2'd3;

    localparam logic [1:0] REG_ACK     = 2'd0;
    localparam logic [1:0] REG_IPI     = 2'd1;
    localparam logic [1:0] REG_MASK    = 2'd2;
    localparam logic [1:0] REG_PENDING = 2'd3;

    localparam logic [63:0] NOINT = '1;

endpackage

// File: rtl/pi1_intctrl_rrpick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N. With ptr tied to zero it is a plain lowest-index pick.
module pi1_intctrl_rrpick #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          vld
);

    logic [2*N-1:0] dbl;

    // Rotating a doubled copy turns the wrap-around search into a linear scan.
    assign dbl = {req, req} >> ptr;

    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!vld && dbl[k]) begin
                vld = 1'b1;
                idx = PW'((32'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/pi1_intctrl.sv
// pi1 slave interrupt controller: latches source edges and IPIs, dispatches
// one interrupt per cycle to a ready PU and returns its id on RW to ACK.
module pi1_intctrl
    import pi1_intctrl_pkg::*;
#(
    parameter int unsigned ARCHBITSZ = 32,
    parameter int unsigned PUCOUNT   = 1,
    parameter int unsigned SRCCOUNT  = 2,
    parameter int unsigned ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             pi1_op_i,
    input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]   pi1_data_i,
    output logic [ARCHBITSZ-1:0]   pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
    output logic                   pi1_rdy_o,
    input  logic [SRCCOUNT-1:0]    src_i,
    output logic [PUCOUNT-1:0]     intrqst_o,
    input  logic [PUCOUNT-1:0]     intrdy_i
);

    localparam int unsigned PW = (PUCOUNT > 1) ? $clog2(PUCOUNT) : 1;
    localparam int unsigned SW = (SRCCOUNT > 1) ? $clog2(SRCCOUNT) : 1;
    localparam int unsigned IW = $clog2(SRCCOUNT + 1);

    logic [SRCCOUNT-1:0] mask, pending, src_q;
    logic [PUCOUNT-1:0]  ipi;
    logic [PW-1:0]       rr;
    logic [IW-1:0]       id_q [PUCOUNT];

    logic                 acc, wr, rd, ack_hit;
    logic [1:0]           rsel;
    logic [IW-1:0]        ack_id, disp_id;
    logic [ARCHBITSZ-1:0] rdata;
    logic [PUCOUNT-1:0]   ack_vec, ipi_set, elig, disp_vec, ipi_clr;
    logic [SRCCOUNT-1:0]  pend_clr, wclr, keep, mask_n, rise;
    logic [PW-1:0]        ipi_idx, pu_idx, rr_next;
    logic [SW-1:0]        src_idx;
    logic                 ipi_vld, pu_vld, src_vld;
    logic                 unused_c;

    assign unused_c = ^{pi1_sel_i, pi1_addr_i[ADDRBITSZ-1:2]};

    // Bus decode, ACK lookup, read mux and register write intents.
    always_comb begin
        acc     = pi1_rdy_o && (pi1_op_i != PINOOP);
        wr      = acc && (pi1_op_i == PIWROP || pi1_op_i == PIRWOP);
        rd      = acc && (pi1_op_i == PIRDOP || pi1_op_i == PIRWOP);
        rsel    = pi1_addr_i[1:0];
        ack_vec = '0;
        ipi_set = '0;
        ack_hit = 1'b0;
        ack_id  = '0;
        for (int unsigned i = 0; i < PUCOUNT; i++) begin
            if (pi1_data_i == ARCHBITSZ'(i)) begin
                ack_vec[i] = acc && (pi1_op_i == PIRWOP) && (rsel == REG_ACK);
                ipi_set[i] = wr && (rsel == REG_IPI);
                if (intrqst_o[i]) begin
                    ack_hit = 1'b1;
                    ack_id  = id_q[i];
                end
            end
        end

        rdata = ARCHBITSZ'(NOINT);
        case (rsel)
            REG_ACK:  if (pi1_op_i == PIRWOP && ack_hit) rdata = ARCHBITSZ'(ack_id);
            REG_IPI:  rdata = ARCHBITSZ'(ipi);
            REG_MASK: rdata = ARCHBITSZ'(mask);
            default:  rdata = ARCHBITSZ'(pending);
        endcase

        mask_n = mask;
        keep   = '1;
        wclr   = '0;
        if (wr && rsel == REG_MASK) begin
            mask_n = pi1_data_i[SRCCOUNT-1:0];
            keep   = pi1_data_i[SRCCOUNT-1:0];
        end
        if (wr && rsel == REG_PENDING) wclr = pi1_data_i[SRCCOUNT-1:0];
        // Old mask qualifies the edge, so a same-cycle MASK write does not affect it.
        rise = src_i & ~src_q & mask;
    end

    assign elig = intrdy_i & ~intrqst_o & ~ack_vec;

    pi1_intctrl_rrpick #(.N(PUCOUNT), .PW(PW)) u_ipi_pick (
        .req(elig & ipi), .ptr('0), .idx(ipi_idx), .vld(ipi_vld)
    );

    pi1_intctrl_rrpick #(.N(SRCCOUNT), .PW(SW)) u_src_pick (
        .req(pending), .ptr('0), .idx(src_idx), .vld(src_vld)
    );

    pi1_intctrl_rrpick #(.N(PUCOUNT), .PW(PW)) u_pu_pick (
        .req(elig), .ptr(rr), .idx(pu_idx), .vld(pu_vld)
    );

    // Single dispatch per cycle: IPIs first, then lowest pending source.
    always_comb begin
        disp_vec = '0;
        ipi_clr  = '0;
        pend_clr = '0;
        disp_id  = IW'(SRCCOUNT);
        rr_next  = rr;
        if (ipi_vld) begin
            for (int unsigned i = 0; i < PUCOUNT; i++) begin
                disp_vec[i] = (ipi_idx == PW'(i));
                ipi_clr[i]  = (ipi_idx == PW'(i));
            end
        end else if (src_vld && pu_vld) begin
            disp_id = IW'(src_idx);
            for (int unsigned i = 0; i < PUCOUNT; i++) disp_vec[i] = (pu_idx == PW'(i));
            for (int unsigned j = 0; j < SRCCOUNT; j++) pend_clr[j] = (src_idx == SW'(j));
            rr_next = (pu_idx == PW'(PUCOUNT - 1)) ? '0 : PW'(pu_idx + 1'b1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pi1_rdy_o  <= 1'b0;
            pi1_data_o <= '0;
            intrqst_o  <= '0;
            mask       <= '0;
            pending    <= '0;
            src_q      <= '0;
            ipi        <= '0;
            rr         <= '0;
            for (int unsigned i = 0; i < PUCOUNT; i++) id_q[i] <= '0;
        end else begin
            pi1_rdy_o <= 1'b1;
            if (rd) pi1_data_o <= rdata;
            src_q     <= src_i;
            mask      <= mask_n;
            // New captures win over dispatch, W1C and mask-driven clears.
            pending   <= (pending & ~pend_clr & ~wclr & keep) | rise;
            ipi       <= (ipi & ~ipi_clr) | ipi_set;
            intrqst_o <= (intrqst_o & ~ack_vec) | disp_vec;
            rr        <= rr_next;
            for (int unsigned i = 0; i < PUCOUNT; i++) begin
                if (disp_vec[i]) id_q[i] <= disp_id;
            end
        end
    end

endmodule

// File: tb/tb_pi1_intctrl.sv
// Bench for pi1_intctrl (2 PUs, 2 sources): directed scenarios with literal
// expectations, then random traffic checked every cycle against a rule model.
module tb_pi1_intctrl;

    localparam int unsigned P   = 2;
    localparam int unsigned S   = 2;
    localparam int unsigned ADW = 30;

    localparam logic [1:0] OP_WR = 2'd1, OP_RD = 2'd2, OP_RW = 2'd3;
    localparam logic [1:0] A_ACK = 2'd0, A_IPI = 2'd1, A_MASK = 2'd2, A_PEND = 2'd3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     op = 2'd0;
    logic [ADW-1:0] addr = '0;
    logic [31:0]    wdata = '0;
    logic [31:0]    rdata;
    logic [3:0]     sel = 4'hf;
    logic           rdy;
    logic [S-1:0]   src = '0;
    logic [P-1:0]   req;
    logic [P-1:0]   irdy = '0;

    int checks = 0;
    int errors = 0;

    pi1_intctrl #(.ARCHBITSZ(32), .PUCOUNT(P), .SRCCOUNT(S)) dut (
        .clk_i(clk), .rst_i(rst_n), .pi1_op_i(op), .pi1_addr_i(addr),
        .pi1_data_i(wdata), .pi1_data_o(rdata), .pi1_sel_i(sel),
        .pi1_rdy_o(rdy), .src_i(src), .intrqst_o(req), .intrdy_i(irdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_rdy = 1'b0;
    logic [31:0] m_data = '0;
    bit          m_mask [S];
    bit          m_pend [S];
    bit          m_prev [S];
    bit          m_ipi  [P];
    bit          m_req  [P];
    int          m_id   [P];
    int          m_rr = 0;

    function automatic bit can_take(int p, int ackto);
        return irdy[p] && !m_req[p] && (p != ackto);
    endfunction

    task automatic model_step();
        int          r, ackto, tgt, sid, s0, p;
        bit          acc, wr, rd;
        bit          rise [S];
        logic [31:0] d, rv;
        d     = wdata;
        r     = int'(addr[1:0]);
        acc   = m_rdy && (op != 2'd0);
        wr    = acc && (op == OP_WR || op == OP_RW);
        rd    = acc && (op == OP_RD || op == OP_RW);
        ackto = (acc && op == OP_RW && r == 0 && d < P) ? int'(d) : -1;

        rv = 32'hFFFF_FFFF;
        if (r == 0) begin
            if (op == OP_RW && ackto >= 0 && m_req[ackto]) rv = 32'(m_id[ackto]);
        end else begin
            rv = '0;
            if (r == 1) for (int i = 0; i < P; i++) rv[i] = m_ipi[i];
            if (r == 2) for (int i = 0; i < S; i++) rv[i] = m_mask[i];
            if (r == 3) for (int i = 0; i < S; i++) rv[i] = m_pend[i];
        end

        tgt = -1;
        sid = -1;
        for (int q = 0; q < P; q++)
            if (tgt < 0 && can_take(q, ackto) && m_ipi[q]) begin tgt = q; sid = S; end
        if (tgt < 0) begin
            s0 = -1;
            for (int s = S - 1; s >= 0; s--) if (m_pend[s]) s0 = s;
            if (s0 >= 0)
                for (int k = 0; k < P; k++) begin
                    p = (m_rr + k) % P;
                    if (tgt < 0 && can_take(p, ackto)) begin tgt = p; sid = s0; end
                end
        end

        for (int s = 0; s < S; s++) rise[s] = src[s] && !m_prev[s] && m_mask[s];
        if (tgt >= 0 && sid < S) m_pend[sid] = 1'b0;
        if (tgt >= 0 && sid == S) m_ipi[tgt] = 1'b0;
        if (wr && r == 3) for (int s = 0; s < S; s++) if (d[s]) m_pend[s] = 1'b0;
        if (wr && r == 2)
            for (int s = 0; s < S; s++) begin
                m_mask[s] = d[s];
                if (!d[s]) m_pend[s] = 1'b0;
            end
        for (int s = 0; s < S; s++) if (rise[s]) m_pend[s] = 1'b1;
        if (wr && r == 1 && d < P) m_ipi[int'(d)] = 1'b1;
        if (ackto >= 0) m_req[ackto] = 1'b0;
        if (tgt >= 0) begin
            m_req[tgt] = 1'b1;
            m_id[tgt]  = sid;
            if (sid < S) m_rr = (tgt + 1) % P;
        end
        for (int s = 0; s < S; s++) m_prev[s] = src[s];
        if (rd) m_data = rv;
        m_rdy = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy  = 1'b0;
            m_data = '0;
            m_rr   = 0;
            for (int s = 0; s < S; s++) begin m_mask[s] = 0; m_pend[s] = 0; m_prev[s] = 0; end
            for (int q = 0; q < P; q++) begin m_ipi[q] = 0; m_req[q] = 0; m_id[q] = 0; end
        end else begin
            model_step();
        end
    end

    logic [P-1:0] exp_req;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int q = 0; q < P; q++) exp_req[q] = m_req[q];
            chk("cyc_rdy", 32'(rdy), 32'(m_rdy));
            chk("cyc_data", rdata, m_data);
            chk("cyc_intrqst", 32'(req), 32'(exp_req));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus(input logic [1:0] o, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] q);
        @(negedge clk);
        op = o; addr = ADW'(a); wdata = d;
        @(negedge clk);
        op = 2'd0; wdata = '0;
        q = rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        op = 2'd0; src = '0; irdy = '0; wdata = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [31:0] q;

    initial begin
        // Reset and idle
        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_intrqst", 32'(req), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 32'(rdy), 32'd1);
        chk("idle_intrqst", 32'(req), 32'd0);
        bus(OP_RD, A_MASK, 32'd0, q);
        chk("rd_mask_reset", q, 32'd0);

        // Single edge, two-cycle latency, ACK and re-ACK
        bus(OP_WR, A_MASK, 32'd1, q);
        irdy = 2'b11;
        src  = 2'b01;
        @(negedge clk); src = 2'b00;
        chk("lat_one_cycle", 32'(req), 32'd0);
        @(negedge clk);
        chk("lat_two_cycles", 32'(req), 32'b01);
        bus(OP_RW, A_ACK, 32'd0, q);
        chk("ack0_id", q, 32'd0);
        chk("ack0_clears", 32'(req), 32'd0);
        bus(OP_RW, A_ACK, 32'd0, q);
        chk("ack0_again", q, 32'hFFFF_FFFF);

        // Two simultaneous edges spread round-robin
        do_reset();
        bus(OP_WR, A_MASK, 32'd3, q);
        irdy = 2'b11;
        src  = 2'b11;
        @(negedge clk); src = 2'b00;
        @(negedge clk);
        chk("rr_first", 32'(req), 32'b01);
        @(negedge clk);
        chk("rr_second", 32'(req), 32'b11);
        bus(OP_RW, A_ACK, 32'd0, q);
        chk("rr_ack0", q, 32'd0);
        bus(OP_RW, A_ACK, 32'd1, q);
        chk("rr_ack1", q, 32'd1);

        // IPI beats a pending source
        do_reset();
        bus(OP_WR, A_MASK, 32'd1, q);
        src = 2'b01;
        @(negedge clk); src = 2'b00;
        bus(OP_WR, A_IPI, 32'd1, q);
        bus(OP_RD, A_IPI, 32'd0, q);
        chk("ipi_bitmap", q, 32'd2);
        bus(OP_RD, A_PEND, 32'd0, q);
        chk("pend_before_ipi", q, 32'd1);
        irdy = 2'b10;
        @(negedge clk);
        chk("ipi_dispatch", 32'(req), 32'b10);
        bus(OP_RW, A_ACK, 32'd1, q);
        chk("ipi_ack_id", q, 32'd2);
        @(negedge clk);
        chk("src_after_ipi", 32'(req), 32'b10);
        bus(OP_RW, A_ACK, 32'd1, q);
        chk("src_ack_id", q, 32'd0);
        chk("all_acked", 32'(req), 32'd0);

        // Mask clears pending; capture beats W1C
        do_reset();
        bus(OP_WR, A_MASK, 32'd1, q);
        src = 2'b01;
        @(negedge clk); src = 2'b00;
        @(negedge clk);
        bus(OP_RD, A_PEND, 32'd0, q);
        chk("pend_set", q, 32'd1);
        bus(OP_WR, A_MASK, 32'd0, q);
        bus(OP_RD, A_PEND, 32'd0, q);
        chk("mask_clears_pend", q, 32'd0);
        irdy = 2'b01;
        repeat (2) @(negedge clk);
        chk("masked_no_req", 32'(req), 32'd0);
        irdy = 2'b00;
        bus(OP_WR, A_MASK, 32'd1, q);
        src = 2'b01;
        @(negedge clk); src = 2'b00;
        @(negedge clk);
        src = 2'b01; op = OP_WR; addr = ADW'(A_PEND); wdata = 32'd1;
        @(negedge clk);
        src = 2'b00; op = 2'd0; wdata = '0;
        bus(OP_RD, A_PEND, 32'd0, q);
        chk("capture_beats_w1c", q, 32'd1);

        // Async reset with an ACK in flight
        do_reset();
        bus(OP_WR, A_MASK, 32'd1, q);
        bus(OP_RD, A_ACK, 32'd0, q);
        chk("rd_ack_noint", q, 32'hFFFF_FFFF);
        irdy = 2'b01;
        src  = 2'b01;
        @(negedge clk); src = 2'b00;
        @(negedge clk);
        chk("pre_reset_req", 32'(req), 32'b01);
        op = OP_RW; addr = ADW'(A_ACK); wdata = 32'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rdy", 32'(rdy), 32'd0);
        chk("async_data", rdata, 32'd0);
        chk("async_intrqst", 32'(req), 32'd0);
        op = 2'd0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        bus(OP_RW, A_ACK, 32'd0, q);
        chk("ack_after_reset", q, 32'hFFFF_FFFF);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            op    = ($urandom_range(0, 9) < 4) ? 2'd0 : 2'($urandom_range(1, 3));
            addr  = ADW'($urandom);
            wdata = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 3));
            src   = 2'($urandom);
            irdy  = 2'($urandom);
            if (i == 2000) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        op = 2'd0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
